cache_ctrl_wb_burst: RTL and testbench
======================================

Name: cache_ctrl_wb_burst

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache controller with multi-word lines, byte-write strobes and a full-cache flush.
- Sits between the CPU load/store port and the word-wide memory controller.
- Successor to the single-word cache controller; adds line bursts, valid/ready handshakes on both sides, and flush.
- Tag, valid, dirty and data arrays are internal flop arrays.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width; byte offset bits BO_W = log2(DATA_W/8).
- IDX_W, 5, index bits; 2^IDX_W lines.
- WPL, 4, words per line; power of two, 1 or more. Word-offset bits WO_W = log2(WPL), 0 when WPL = 1.
- Derived TAG_W = ADDR_W - IDX_W - WO_W - BO_W.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  controller accepts request this cycle.
- cpu_req_rw  in  1  0 = read, 1 = write.
- cpu_req_addr  in  ADDR_W  byte address, word aligned.
- cpu_req_wdata  in  DATA_W  write data.
- cpu_req_wstrb  in  DATA_W/8  byte enables for writes.
- cpu_rsp_valid  out  1  one-cycle response pulse.
- cpu_rsp_rdata  out  DATA_W  read data, or the merged word for writes.
- mem_req_valid  out  1  memory word request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_rw  out  1  0 = read, 1 = write.
- mem_req_addr  out  ADDR_W  word-aligned address.
- mem_req_wdata  out  DATA_W  write-back data.
- mem_rsp_valid  in  1  read data returned.
- mem_rsp_rdata  in  DATA_W  read data.
- flush_req  in  1  level request to flush the whole cache.
- flush_done  out  1  one-cycle pulse when flush is complete.

Behaviour:
- Reset, while iRST is high:
  - state = IDLE; all valid and dirty bits = 0.
  - cpu_req_ready = 0, cpu_rsp_valid = 0, mem_req_valid = 0, flush_done = 0.
  - mem_req_rw, mem_req_addr, mem_req_wdata, cpu_rsp_rdata = 0.
  - Reset mid-transaction abandons the transaction; no completion is emitted.
- Address split: tag = [ADDR_W-1 : IDX_W+WO_W+BO_W], index = next IDX_W bits, word = next WO_W bits.
- States: IDLE, LOOKUP, WRITEBACK, FILL, FLUSH.
- IDLE:
  - cpu_req_ready = 1 only in IDLE with iRST low.
  - On valid && ready, latch rw, addr, wdata, wstrb and go to LOOKUP.
  - flush_req is taken only when cpu_req_valid is low; the CPU wins a same-cycle tie. Taking flush goes to FLUSH with index counter = 0.
- LOOKUP:
  - Hit means valid[idx] and the tag matches.
  - Read hit: cpu_rsp_valid is registered and pulses the next cycle with the addressed word.
  - Write hit: merge wstrb bytes into the word, set dirty[idx], pulse cpu_rsp_valid the next cycle with the merged word.
  - After a hit, return to IDLE. Hit latency: response exactly 2 cycles after the accept edge.
  - Miss with victim valid && dirty: go to WRITEBACK.
  - Miss otherwise: go to FILL.
- WRITEBACK:
  - Issue WPL write requests, mem_req_addr = {victim_tag, idx, w, 0} for w = 0..WPL-1, with mem_req_wdata = line word w.
  - Advance w only on mem_req_valid && mem_req_ready.
  - After the last accept: clear dirty[idx], go to FILL.
- FILL:
  - For w = 0..WPL-1, issue a read request at {req_tag, idx, w, 0}.
  - After its accept, deassert mem_req_valid and wait for mem_rsp_valid; store mem_rsp_rdata into word w. Only one read is outstanding.
  - After the last word: tag = req_tag, valid = 1, dirty = 0, return to LOOKUP, which then hits and completes the original request.
- Handshake rules:
  - Once asserted, mem_req_valid and its addr, rw and wdata are held stable until accepted; no retraction.
  - mem_rsp_valid outside a FILL wait is ignored.
  - cpu_rsp_valid never asserts except from LOOKUP.
- FLUSH:
  - For idx = 0..2^IDX_W-1: if valid && dirty, write back WPL words as in WRITEBACK. Then clear valid and dirty.
  - After the last index, pulse flush_done for 1 cycle and return to IDLE.
  - cpu_req_ready = 0 throughout FLUSH.
  - Clean lines cost 1 cycle per index.
- Counters: word and index counters wrap to 0 at the end of each burst or walk; no overflow into adjacent fields.

Test Plan (WPL = 4, IDX_W = 5, DATA_W = 32: index = addr[8:4], tag = addr[31:9]):
1. Cold read of 0x100, memory returns 0xA0..0xA3 -> reads at 0x100, 0x104, 0x108, 0x10C, then cpu_rsp_rdata = 0xA0. A following read of 0x104 -> rsp 0xA1 exactly 2 cycles after accept, with no mem_req_valid.
2. Word at 0x108 = 0x11223344; write 0xAABBCCDD with wstrb 4'b0010 -> rsp 0x1122CC44; a later read of 0x108 returns 0x1122CC44; dirty[0x10] = 1.
3. After test 2, read 0x300 (same index, tag 1) -> 4 writes to 0x100..0x10C with data A0, A1, 1122CC44, A3, then 4 reads 0x300..0x30C, then rsp = mem word 0x300.
4. Hold mem_req_ready low for 3 cycles during WRITEBACK word 1 -> mem_req_valid stays 1 and addr/wdata stay at 0x104 / line word 1 every cycle.
5. Two dirty lines (indices 0x10 and 0x11) plus one clean line, then assert flush_req -> exactly 8 write requests, flush_done pulses once, a subsequent read of 0x100 misses and refills.
6. Assert iRST during FILL after 2 words returned -> all outputs at reset values in the same cycle. After release, reading that address misses and issues 4 reads again.

Source files
------------

// File: rtl/cache_ctrl_wb_burst.sv
// cache_ctrl_wb_burst: direct-mapped write-back/write-allocate cache with line bursts and full flush
module cache_ctrl_wb_burst #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int WPL    = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_rw,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_req_wdata,
  input  logic [DATA_W/8-1:0] cpu_req_wstrb,
  output logic                cpu_rsp_valid,
  output logic [DATA_W-1:0]   cpu_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  input  logic                flush_req,
  output logic                flush_done
);
  localparam int BO_W  = $clog2(DATA_W/8);
  localparam int WO_W  = $clog2(WPL);
  localparam int WC_W  = WO_W > 0 ? WO_W : 1;
  localparam int TAG_W = ADDR_W - IDX_W - WO_W - BO_W;
  localparam int NB    = DATA_W/8;
  localparam int LINES = 1 << IDX_W;
  localparam logic [WC_W-1:0] W0 = '0;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, FLUSH} state_t;
  state_t              state;
  logic [LINES-1:0]    valid, dirty;
  logic [TAG_W-1:0]    tags [LINES];
  logic [DATA_W-1:0]   data [LINES][WPL];
  logic                req_rw, waiting;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata, word, merged;
  logic [NB-1:0]       req_wstrb;
  logic [WC_W-1:0]     wcnt, wnext, rword;
  logic [IDX_W-1:0]    icnt, ridx;
  logic [TAG_W-1:0]    rtag;
  logic                hit, victim_dirty, acc, wlast, fill_word;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                                                  input logic [WC_W-1:0] w);
    return (ADDR_W'(t) << (IDX_W + WO_W + BO_W)) | (ADDR_W'(i) << (WO_W + BO_W)) | (ADDR_W'(w) << BO_W);
  endfunction

  assign rtag          = TAG_W'(req_addr >> (IDX_W + WO_W + BO_W));
  assign ridx          = IDX_W'(req_addr >> (WO_W + BO_W));
  assign rword         = WO_W > 0 ? WC_W'(req_addr >> BO_W) : W0;
  assign hit           = valid[ridx] && tags[ridx] == rtag;
  assign victim_dirty  = valid[ridx] && dirty[ridx];
  assign word          = data[ridx][rword];
  assign acc           = mem_req_valid && mem_req_ready;
  assign wlast         = wcnt == WC_W'(WPL - 1);
  assign wnext         = wlast ? W0 : wcnt + 1'b1;
  assign fill_word     = state == FILL && waiting && mem_rsp_valid;
  assign cpu_req_ready = state == IDLE && !iRST;

  always_comb begin
    merged = word;
    for (int b = 0; b < NB; b++) merged[8*b +: 8] = req_wstrb[b] ? req_wdata[8*b +: 8] : word[8*b +: 8];
  end

  always_ff @(posedge iCLK) begin
    if (state == LOOKUP && hit && req_rw) data[ridx][rword] <= merged;
    if (fill_word) data[ridx][wcnt] <= mem_rsp_rdata;
    if (fill_word && wlast) tags[ridx] <= rtag;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      flush_done    <= 1'b0;
      req_rw        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_wstrb     <= '0;
      wcnt          <= '0;
      icnt          <= '0;
      waiting       <= 1'b0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      flush_done    <= 1'b0;
      case (state)
        IDLE:
          if (cpu_req_valid) begin
            req_rw    <= cpu_req_rw;
            req_addr  <= cpu_req_addr;
            req_wdata <= cpu_req_wdata;
            req_wstrb <= cpu_req_wstrb;
            state     <= LOOKUP;
          end else if (flush_req) begin
            icnt  <= '0;
            wcnt  <= '0;
            state <= FLUSH;
          end
        LOOKUP:
          if (hit) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_rdata <= req_rw ? merged : word;
            if (req_rw) dirty[ridx] <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt          <= '0;
            mem_req_valid <= 1'b1;
            mem_req_rw    <= victim_dirty;
            mem_req_addr  <= victim_dirty ? line_addr(tags[ridx], ridx, W0) : line_addr(rtag, ridx, W0);
            mem_req_wdata <= data[ridx][W0];
            state         <= victim_dirty ? WRITEBACK : FILL;
          end
        WRITEBACK:
          if (acc) begin
            wcnt          <= wnext;
            mem_req_addr  <= wlast ? line_addr(rtag, ridx, W0) : line_addr(tags[ridx], ridx, wnext);
            mem_req_wdata <= data[ridx][wnext];
            if (wlast) begin
              dirty[ridx] <= 1'b0;
              mem_req_rw  <= 1'b0;
              state       <= FILL;
            end
          end
        FILL:
          if (!waiting) begin
            if (acc) begin
              mem_req_valid <= 1'b0;
              waiting       <= 1'b1;
            end
          end else if (mem_rsp_valid) begin
            waiting <= 1'b0;
            wcnt    <= wnext;
            if (wlast) begin
              valid[ridx] <= 1'b1;
              dirty[ridx] <= 1'b0;
              state       <= LOOKUP;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= line_addr(rtag, ridx, wnext);
            end
          end
        FLUSH:
          // each index either streams its dirty line out or retires in one cycle
          if (mem_req_valid && acc && !wlast) begin
            wcnt          <= wnext;
            mem_req_addr  <= line_addr(tags[icnt], icnt, wnext);
            mem_req_wdata <= data[icnt][wnext];
          end else if (!mem_req_valid && valid[icnt] && dirty[icnt]) begin
            mem_req_valid <= 1'b1;
            mem_req_rw    <= 1'b1;
            mem_req_addr  <= line_addr(tags[icnt], icnt, W0);
            mem_req_wdata <= data[icnt][W0];
          end else if (!mem_req_valid || acc) begin
            mem_req_valid <= 1'b0;
            wcnt          <= '0;
            valid[icnt]   <= 1'b0;
            dirty[icnt]   <= 1'b0;
            icnt          <= icnt + 1'b1;
            if (&icnt) begin
              flush_done <= 1'b1;
              state      <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl_wb_burst.sv
// tb_cache_ctrl_wb_burst: scoreboard bench with a flat-memory reference model and a randomised memory slave
module tb_cache_ctrl_wb_burst;
  logic        iCLK = 0, iRST = 1;
  logic        cpu_req_valid = 0, cpu_req_ready, cpu_req_rw = 0;
  logic [31:0] cpu_req_addr = 0, cpu_req_wdata = 0, cpu_rsp_rdata;
  logic [3:0]  cpu_req_wstrb = 0;
  logic        cpu_rsp_valid, mem_req_valid, mem_req_ready = 0, mem_req_rw, mem_rsp_valid = 0;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata = 0;
  logic        flush_req = 0, flush_done;

  cache_ctrl_wb_burst dut (
    .iCLK(iCLK), .iRST(iRST),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 iCLK = ~iCLK;

  typedef struct { logic rw; logic [31:0] addr; logic [31:0] wdata; } mreq_t;
  mreq_t       mlog[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          tests = 0, fails = 0, cyc = 0, acc_cyc = 0, rsp_cyc = 0;
  int          rsp_given = 0, done_pulses = 0, stall_left = 0, stall_hits = 0, lat = 0;
  logic [31:0] stall_addr = 0, paddr = 0, prev_addr = 0, prev_wdata = 0;
  logic        pend = 0, pv = 0, prev_rw = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // memory slave: random ready, random read latency, one read outstanding
  initial forever begin
    @(negedge iCLK);
    if (iRST) begin
      pend = 0; pv = 0; mem_rsp_valid = 0; mem_req_ready = 0;
    end else begin
      if (pv) begin
        check("hold_valid", {31'b0, mem_req_valid}, 1);
        check("hold_addr", mem_req_addr, prev_addr);
        check("hold_wdata", mem_req_wdata, prev_wdata);
        check("hold_rw", {31'b0, mem_req_rw}, {31'b0, prev_rw});
      end
      mem_rsp_valid = 0;
      if (pend) begin
        if (lat == 0) begin
          mem_rsp_valid = 1; mem_rsp_rdata = mem_rd(paddr); pend = 0; rsp_given++;
        end else lat--;
      end
      if (stall_left > 0 && mem_req_valid && mem_req_rw && mem_req_addr == stall_addr) begin
        mem_req_ready = 0; stall_left--; stall_hits++;
      end else mem_req_ready = ($urandom_range(0, 3) != 0);
      pv = mem_req_valid && !mem_req_ready;
      prev_rw = mem_req_rw; prev_addr = mem_req_addr; prev_wdata = mem_req_wdata;
      if (mem_req_valid && mem_req_ready) begin
        mlog.push_back('{mem_req_rw, mem_req_addr, mem_req_wdata});
        if (mem_req_rw) mem_arr[mem_req_addr] = mem_req_wdata;
        else begin pend = 1; lat = $urandom_range(0, 2); paddr = mem_req_addr; end
      end
    end
  end

  // response monitor: every CPU response must match the head of the scoreboard
  initial forever begin
    @(negedge iCLK);
    if (!iRST && cpu_rsp_valid) begin
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rsp: got %h expected none", cpu_rsp_rdata);
      end else check("cpu_rsp", cpu_rsp_rdata, exp_q.pop_front());
    end
    if (!iRST && flush_done) done_pulses++;
  end

  task automatic cpu_issue(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    logic [31:0] e;
    @(negedge iCLK);
    cpu_req_valid = 1; cpu_req_rw = rw; cpu_req_addr = a; cpu_req_wdata = d; cpu_req_wstrb = s;
    while (!cpu_req_ready && n < 2000) begin @(negedge iCLK); n++; end
    if (!cpu_req_ready) timeout("cpu_accept");
    else begin
      acc_cyc = cyc;
      e = rw ? merge(ref_rd(a), d, s) : ref_rd(a);
      if (rw) ref_mem[a] = e;
      exp_q.push_back(e);
    end
    @(negedge iCLK);
    cpu_req_valid = 0;
  endtask

  task automatic cpu_wait();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(negedge iCLK); n++; end
    if (exp_q.size() > 0) begin timeout("cpu_rsp"); exp_q.delete(); end
  endtask

  task automatic cpu_op(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cpu_issue(rw, a, d, s);
    cpu_wait();
  endtask

  task automatic do_flush();
    int n = 0;
    done_pulses = 0;
    @(negedge iCLK);
    flush_req = 1;
    while (!flush_done && n < 5000) begin @(negedge iCLK); n++; end
    flush_req = 0;
    if (!flush_done) timeout("flush_done");
    repeat (4) @(negedge iCLK);
    check("flush_pulses", done_pulses, 1);
  endtask

  logic [31:0] wa [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [31:0] wd [4] = '{32'hA0, 32'hA1, 32'h1122CC44, 32'hA3};

  initial begin
    repeat (3) @(negedge iCLK);
    check("rst_ready", {31'b0, cpu_req_ready}, 0);
    check("rst_rsp_valid", {31'b0, cpu_rsp_valid}, 0);
    check("rst_mem_valid", {31'b0, mem_req_valid}, 0);
    check("rst_flush_done", {31'b0, flush_done}, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_rdata", cpu_rsp_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      mem_arr[32'h100 + 4*i] = 32'hA0 + i;
      ref_mem[32'h100 + 4*i] = 32'hA0 + i;
    end
    iRST = 0;
    @(negedge iCLK);
    check("ready_after_rst", {31'b0, cpu_req_ready}, 1);
    // cold miss fills the whole line in order, then a hit with no memory traffic
    mlog.delete();
    cpu_op(0, 32'h100, 0, 0);
    check("t1_nreq", mlog.size(), 4);
    if (mlog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("t1_rw", {31'b0, mlog[i].rw}, 0);
        check("t1_addr", mlog[i].addr, 32'h100 + 4*i);
      end
    mlog.delete();
    cpu_op(0, 32'h104, 0, 0);
    check("t1_hit_nreq", mlog.size(), 0);
    check("t1_hit_latency", rsp_cyc - acc_cyc, 2);
    // byte-strobe merge on a hit
    cpu_op(1, 32'h108, 32'h11223344, 4'hF);
    cpu_op(1, 32'h108, 32'hAABBCCDD, 4'b0010);
    check("t2_model", ref_rd(32'h108), 32'h1122CC44);
    cpu_op(0, 32'h108, 0, 0);
    // conflict miss on a dirty line with a 3-cycle stall on write-back word 1
    mlog.delete();
    stall_addr = 32'h104; stall_left = 3; stall_hits = 0;
    cpu_op(0, 32'h300, 0, 0);
    check("t4_stall_hits", stall_hits, 3);
    check("t3_nreq", mlog.size(), 8);
    if (mlog.size() == 8)
      for (int i = 0; i < 4; i++) begin
        check("t3_wb_rw", {31'b0, mlog[i].rw}, 1);
        check("t3_wb_addr", mlog[i].addr, wa[i]);
        check("t3_wb_data", mlog[i].wdata, wd[i]);
        check("t3_fill_rw", {31'b0, mlog[i+4].rw}, 0);
        check("t3_fill_addr", mlog[i+4].addr, 32'h300 + 4*i);
      end
    // random traffic over a few indices and tags to force conflicts and write-backs
    for (int k = 0; k < 150; k++)
      cpu_op(1'($urandom_range(0, 1)),
             (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(14, 17)) << 4) | (32'($urandom_range(0, 3)) << 2),
             $urandom, 4'($urandom_range(1, 15)));
    do_flush();
    for (int t = 0; t < 4; t++)
      for (int i = 14; i < 18; i++)
        for (int w = 0; w < 4; w++)
          check("flush_image", mem_rd(32'(t << 9 | i << 4 | w << 2)), ref_rd(32'(t << 9 | i << 4 | w << 2)));
    // two dirty lines and one clean line: exactly eight write-backs
    cpu_op(1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    cpu_op(1, 32'h114, 32'h0BAD_F00D, 4'b1001);
    cpu_op(0, 32'h120, 0, 0);
    mlog.delete();
    do_flush();
    check("t5_nreq", mlog.size(), 8);
    if (mlog.size() == 8)
      for (int i = 0; i < 8; i++) begin
        check("t5_rw", {31'b0, mlog[i].rw}, 1);
        check("t5_addr", mlog[i].addr, 32'h100 + 4*i);
      end
    check("t5_mem_100", mem_rd(32'h100), 32'hDEAD_BEEF);
    mlog.delete();
    cpu_op(0, 32'h100, 0, 0);
    check("t5_refill_nreq", mlog.size(), 4);
    // reset in the middle of a fill abandons it
    mlog.delete();
    rsp_given = 0;
    cpu_issue(0, 32'h500, 0, 0);
    for (int n = 0; n < 2000 && rsp_given < 2; n++) @(negedge iCLK);
    if (rsp_given < 2) timeout("t6_fill_progress");
    @(posedge iCLK);
    #1 iRST = 1;
    #1;
    check("t6_ready", {31'b0, cpu_req_ready}, 0);
    check("t6_rsp_valid", {31'b0, cpu_rsp_valid}, 0);
    check("t6_mem_valid", {31'b0, mem_req_valid}, 0);
    check("t6_mem_rw", {31'b0, mem_req_rw}, 0);
    check("t6_mem_addr", mem_req_addr, 0);
    check("t6_mem_wdata", mem_req_wdata, 0);
    check("t6_rdata", cpu_rsp_rdata, 0);
    check("t6_flush_done", {31'b0, flush_done}, 0);
    exp_q.delete();
    repeat (2) @(negedge iCLK);
    iRST = 0;
    repeat (3) @(negedge iCLK);
    mlog.delete();
    cpu_op(0, 32'h500, 0, 0);
    check("t6_nreq", mlog.size(), 4);
    if (mlog.size() == 4) begin
      check("t6_first", mlog[0].addr, 32'h500);
      check("t6_last", mlog[3].addr, 32'h50C);
    end
    repeat (5) @(negedge iCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
